axi_slv_sram: RTL and testbench

//  Synthesizable AXI4 slave memory: one req/rsp port pair holding a word array, used as a DMA target/source.

---
 rtl/axi_slv_sram.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_axi_slv_sram.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slv_sram.sv
// axi_slv_sram: AXI4 slave backed by a word-wide memory array, used as a DMA source/target.
// Independent read and write FSMs, one burst each in flight; FIXED/INCR/WRAP bursts and
// byte strobes. Out-of-range beats answer DECERR, oversized beats and ATOPs answer SLVERR.
//
// Ports
//   clk_i      in   clock
//   rst_ni     in   asynchronous reset, active low
//   axi_req_i  in   packed AXI4 request, MSB first:
//                   aw{id,addr,len[8],size[3],burst[2],atop[6],user}, aw_valid,
//                   w{data,strb,last,user}, w_valid, b_ready,
//                   ar{id,addr,len[8],size[3],burst[2],user}, ar_valid, r_ready
//   axi_rsp_o  out  packed AXI4 response, MSB first:
//                   aw_ready, w_ready, b{id,resp[2],user}, b_valid,
//                   ar_ready, r{id,data,resp[2],last,user}, r_valid
module axi_slv_sram #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 1,
  parameter int unsigned UserWidth = 1,
  parameter int unsigned NumWords  = 1024,
  localparam int unsigned StrbWidth = DataWidth / 8,
  localparam int unsigned ReqWidth  = 2 * IdWidth + 2 * AddrWidth + 3 * UserWidth + DataWidth +
                                      StrbWidth + 38,
  localparam int unsigned RspWidth  = 2 * IdWidth + 2 * UserWidth + DataWidth + 10
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [ReqWidth-1:0] axi_req_i,
  output logic [RspWidth-1:0] axi_rsp_o
);

  localparam int unsigned OffWidth  = $clog2(StrbWidth);
  localparam int unsigned WordWidth = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [AddrWidth-1:0] ByteSpan = AddrWidth'(NumWords * StrbWidth);
  localparam logic [AddrWidth-1:0] AddrOne  = AddrWidth'(1);
  localparam logic [2:0] MaxSize    = 3'(OffWidth);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;

  typedef struct packed {
    logic [IdWidth-1:0]   aw_id;
    logic [AddrWidth-1:0] aw_addr;
    logic [7:0]           aw_len;
    logic [2:0]           aw_size;
    logic [1:0]           aw_burst;
    logic [5:0]           aw_atop;
    logic [UserWidth-1:0] aw_user;
    logic                 aw_valid;
    logic [DataWidth-1:0] w_data;
    logic [StrbWidth-1:0] w_strb;
    logic                 w_last;
    logic [UserWidth-1:0] w_user;
    logic                 w_valid;
    logic                 b_ready;
    logic [IdWidth-1:0]   ar_id;
    logic [AddrWidth-1:0] ar_addr;
    logic [7:0]           ar_len;
    logic [2:0]           ar_size;
    logic [1:0]           ar_burst;
    logic [UserWidth-1:0] ar_user;
    logic                 ar_valid;
    logic                 r_ready;
  } req_t;

  typedef struct packed {
    logic                 aw_ready;
    logic                 w_ready;
    logic [IdWidth-1:0]   b_id;
    logic [1:0]           b_resp;
    logic [UserWidth-1:0] b_user;
    logic                 b_valid;
    logic                 ar_ready;
    logic [IdWidth-1:0]   r_id;
    logic [DataWidth-1:0] r_data;
    logic [1:0]           r_resp;
    logic                 r_last;
    logic [UserWidth-1:0] r_user;
    logic                 r_valid;
  } rsp_t;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic [0:0] {RIdle, RData} r_state_e;

  req_t req;
  rsp_t rsp;
  assign req       = axi_req_i;
  assign axi_rsp_o = rsp;

  // User sidebands are accepted but carry no meaning here.
  logic unused_user;
  assign unused_user = ^{req.aw_user, req.w_user, req.ar_user};

  // Address of the beat following addr; the first beat of a burst keeps its unaligned address.
  function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] addr,
                                                     input logic [2:0]           size,
                                                     input logic [7:0]           len,
                                                     input logic [1:0]           burst);
    logic [AddrWidth-1:0] step, incr, span, lower;
    step  = AddrOne << size;
    incr  = (addr & ~(step - AddrOne)) + step;
    span  = AddrWidth'({1'b0, len} + 9'd1) << size;
    lower = addr & ~(span - AddrOne);
    case (burst)
      BurstFixed: next_addr = addr;
      BurstWrap:  next_addr = (incr == lower + span) ? lower : incr;
      default:    next_addr = incr;
    endcase
  endfunction

  function automatic logic [WordWidth-1:0] word_idx(input logic [AddrWidth-1:0] addr);
    return addr[OffWidth +: WordWidth];
  endfunction

  logic [DataWidth-1:0] mem_q [NumWords];

  // ---------------- write channel ----------------
  w_state_e             w_state_q;
  logic                 aw_ready_q, w_ready_q, b_valid_q;
  logic [IdWidth-1:0]   b_id_q;
  logic [1:0]           b_resp_q;
  logic [AddrWidth-1:0] w_addr_q;
  logic [7:0]           w_len_q, w_cnt_q;
  logic [2:0]           w_size_q;
  logic [1:0]           w_burst_q;
  logic                 w_err_q;

  logic [1:0] w_beat_resp;
  logic       mem_we, w_final;

  always_comb begin
    w_beat_resp = w_err_q ? RespSlvErr : ((w_addr_q < ByteSpan) ? RespOkay : RespDecErr);
    mem_we      = (w_state_q == WData) && req.w_valid && (w_beat_resp == RespOkay);
    // The beat counter closes the burst even when w_last never shows up.
    w_final     = req.w_last || (w_cnt_q == w_len_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q  <= WIdle;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
      b_resp_q   <= RespOkay;
      w_addr_q   <= '0;
      w_len_q    <= '0;
      w_cnt_q    <= '0;
      w_size_q   <= '0;
      w_burst_q  <= '0;
      w_err_q    <= 1'b0;
    end else begin
      unique case (w_state_q)
        WIdle: begin
          if (req.aw_valid) begin
            b_id_q     <= req.aw_id;
            w_addr_q   <= req.aw_addr;
            w_len_q    <= req.aw_len;
            w_size_q   <= req.aw_size;
            w_burst_q  <= req.aw_burst;
            w_err_q    <= (req.aw_size > MaxSize) || (req.aw_atop != '0);
            w_cnt_q    <= '0;
            b_resp_q   <= RespOkay;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b1;
            w_state_q  <= WData;
          end
        end
        WData: begin
          if (req.w_valid) begin
            if (w_beat_resp > b_resp_q) b_resp_q <= w_beat_resp;
            w_addr_q <= next_addr(w_addr_q, w_size_q, w_len_q, w_burst_q);
            w_cnt_q  <= w_cnt_q + 8'd1;
            if (w_final) begin
              w_ready_q <= 1'b0;
              b_valid_q <= 1'b1;
              w_state_q <= WResp;
            end
          end
        end
        WResp: begin
          if (req.b_ready) begin
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
            w_state_q  <= WIdle;
          end
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  // Array is deliberately not reset; bytes written before a reset survive it.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < StrbWidth; i++) begin
        if (req.w_strb[i]) mem_q[word_idx(w_addr_q)][8*i +: 8] <= req.w_data[8*i +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_e             r_state_q;
  logic                 ar_ready_q, r_valid_q, r_last_q, r_err_q;
  logic [IdWidth-1:0]   r_id_q;
  logic [DataWidth-1:0] r_data_q;
  logic [1:0]           r_resp_q;
  logic [AddrWidth-1:0] r_addr_q;
  logic [7:0]           r_len_q, r_cnt_q;
  logic [2:0]           r_size_q;
  logic [1:0]           r_burst_q;

  // Address, response and data of the beat that would be loaded this cycle. The array is
  // read before any same-cycle write lands, so a colliding read sees the old word.
  logic [AddrWidth-1:0] rd_addr;
  logic                 rd_err;
  logic [1:0]           rd_resp;
  logic [DataWidth-1:0] rd_data;

  always_comb begin
    if (r_state_q == RIdle) begin
      rd_addr = req.ar_addr;
      rd_err  = req.ar_size > MaxSize;
    end else begin
      rd_addr = next_addr(r_addr_q, r_size_q, r_len_q, r_burst_q);
      rd_err  = r_err_q;
    end
    rd_resp = rd_err ? RespSlvErr : ((rd_addr < ByteSpan) ? RespOkay : RespDecErr);
    rd_data = (rd_resp == RespOkay) ? mem_q[word_idx(rd_addr)] : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q  <= RIdle;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_err_q    <= 1'b0;
      r_id_q     <= '0;
      r_data_q   <= '0;
      r_resp_q   <= RespOkay;
      r_addr_q   <= '0;
      r_len_q    <= '0;
      r_cnt_q    <= '0;
      r_size_q   <= '0;
      r_burst_q  <= '0;
    end else begin
      unique case (r_state_q)
        RIdle: begin
          if (req.ar_valid) begin
            r_id_q     <= req.ar_id;
            r_addr_q   <= req.ar_addr;
            r_len_q    <= req.ar_len;
            r_size_q   <= req.ar_size;
            r_burst_q  <= req.ar_burst;
            r_err_q    <= rd_err;
            r_cnt_q    <= '0;
            r_last_q   <= (req.ar_len == 8'd0);
            r_data_q   <= rd_data;
            r_resp_q   <= rd_resp;
            r_valid_q  <= 1'b1;
            ar_ready_q <= 1'b0;
            r_state_q  <= RData;
          end
        end
        RData: begin
          if (req.r_ready) begin
            if (r_last_q) begin
              r_valid_q  <= 1'b0;
              ar_ready_q <= 1'b1;
              r_state_q  <= RIdle;
            end else begin
              r_addr_q <= rd_addr;
              r_cnt_q  <= r_cnt_q + 8'd1;
              r_last_q <= ((r_cnt_q + 8'd1) == r_len_q);
              r_data_q <= rd_data;
              r_resp_q <= rd_resp;
            end
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

  always_comb begin
    rsp          = '0;
    rsp.aw_ready = aw_ready_q;
    rsp.w_ready  = w_ready_q;
    rsp.b_id     = b_id_q;
    rsp.b_resp   = b_resp_q;
    rsp.b_valid  = b_valid_q;
    rsp.ar_ready = ar_ready_q;
    rsp.r_id     = r_id_q;
    rsp.r_data   = r_data_q;
    rsp.r_resp   = r_resp_q;
    rsp.r_last   = r_last_q;
    rsp.r_valid  = r_valid_q;
  end

endmodule

// File: tb/tb_axi_slv_sram.sv
// Randomised bench for axi_slv_sram against a byte-array reference model.
module tb_axi_slv_sram;

  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned IdWidth   = 1;
  localparam int unsigned UserWidth = 1;
  localparam int unsigned NumWords  = 1024;
  localparam int unsigned Span      = NumWords * 8;

  typedef struct packed {
    logic [IdWidth-1:0]   aw_id;
    logic [AddrWidth-1:0] aw_addr;
    logic [7:0]           aw_len;
    logic [2:0]           aw_size;
    logic [1:0]           aw_burst;
    logic [5:0]           aw_atop;
    logic [UserWidth-1:0] aw_user;
    logic                 aw_valid;
    logic [DataWidth-1:0] w_data;
    logic [7:0]           w_strb;
    logic                 w_last;
    logic [UserWidth-1:0] w_user;
    logic                 w_valid;
    logic                 b_ready;
    logic [IdWidth-1:0]   ar_id;
    logic [AddrWidth-1:0] ar_addr;
    logic [7:0]           ar_len;
    logic [2:0]           ar_size;
    logic [1:0]           ar_burst;
    logic [UserWidth-1:0] ar_user;
    logic                 ar_valid;
    logic                 r_ready;
  } req_t;

  typedef struct packed {
    logic                 aw_ready;
    logic                 w_ready;
    logic [IdWidth-1:0]   b_id;
    logic [1:0]           b_resp;
    logic [UserWidth-1:0] b_user;
    logic                 b_valid;
    logic                 ar_ready;
    logic [IdWidth-1:0]   r_id;
    logic [DataWidth-1:0] r_data;
    logic [1:0]           r_resp;
    logic                 r_last;
    logic [UserWidth-1:0] r_user;
    logic                 r_valid;
  } rsp_t;

  logic clk;
  logic rst_n;
  req_t req;
  rsp_t rsp;

  axi_slv_sram #(
    .AddrWidth(AddrWidth),
    .DataWidth(DataWidth),
    .IdWidth  (IdWidth),
    .UserWidth(UserWidth),
    .NumWords (NumWords)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .axi_req_i(req),
    .axi_rsp_o(rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_pass;

  // Reference memory: one byte per address plus a written-flag so never-written bytes are ignored.
  logic [7:0] mdl   [Span];
  bit         mdl_v [Span];

  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  logic [63:0] rd [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Closed-form address of beat i of a burst.
  function automatic logic [63:0] beat_addr(input logic [63:0] start, input int size,
                                            input int len, input int burst, input int i);
    logic [63:0] nb, al, total, lower;
    nb = 64'd1 << size;
    al = (start / nb) * nb;
    if (burst == 0) return start;
    if (burst == 2) begin
      total = nb * 64'(len + 1);
      lower = (start / total) * total;
      return lower + ((al - lower + nb * 64'(i)) % total);
    end
    return (i == 0) ? start : al + nb * 64'(i);
  endfunction

  function automatic logic [1:0] beat_resp(input logic [63:0] a, input int size, input bit bad);
    if (bad || size > 3) return 2'b10;
    if (a >= 64'(Span)) return 2'b11;
    return 2'b00;
  endfunction

  // last_beat: beat index carrying w_last (-1: never asserted).
  task automatic do_write(input logic [63:0] addr, input int len, input int size,
                          input int burst, input logic [5:0] atop, input int last_beat,
                          input logic id, input string tag);
    int beats;
    int cnt;
    int idx;
    logic [63:0] a;
    logic [1:0] r;
    logic [1:0] exp_resp;
    beats = (last_beat >= 0 && last_beat < len) ? last_beat + 1 : len + 1;
    req.aw_id    = id;
    req.aw_addr  = addr;
    req.aw_len   = 8'(len);
    req.aw_size  = 3'(size);
    req.aw_burst = 2'(burst);
    req.aw_atop  = atop;
    req.aw_valid = 1'b1;
    cnt = 0;
    while (!rsp.aw_ready && cnt < 50) begin step(); cnt++; end
    check({tag, "_aw_ready"}, rsp.aw_ready, 1);
    step();
    req.aw_valid = 1'b0;
    check({tag, "_aw_busy"}, rsp.aw_ready, 0);
    for (int i = 0; i < beats; i++) begin
      req.w_valid = 1'b0;
      repeat ($urandom_range(0, 1)) step();
      req.w_data  = wd[i];
      req.w_strb  = ws[i];
      req.w_last  = (i == last_beat);
      req.w_valid = 1'b1;
      cnt = 0;
      while (!rsp.w_ready && cnt < 50) begin step(); cnt++; end
      if (!rsp.w_ready) check({tag, "_w_ready"}, rsp.w_ready, 1);
      step();
    end
    req.w_valid = 1'b0;
    req.w_last  = 1'b0;
    check({tag, "_b_vis"}, rsp.b_valid, 1);
    repeat ($urandom_range(0, 2)) step();
    req.b_ready = 1'b1;
    cnt = 0;
    while (!rsp.b_valid && cnt < 50) begin step(); cnt++; end
    exp_resp = 2'b00;
    for (int i = 0; i < beats; i++) begin
      a = beat_addr(addr, size, len, burst, i);
      r = beat_resp(a, size, atop != 6'd0);
      if (r > exp_resp) exp_resp = r;
      if (r == 2'b00) begin
        for (int j = 0; j < 8; j++) begin
          if (ws[i][j]) begin
            idx = int'(a & ~64'd7) + j;
            mdl[idx]   = wd[i][8*j +: 8];
            mdl_v[idx] = 1'b1;
          end
        end
      end
    end
    check({tag, "_b_resp"}, {rsp.b_valid, rsp.b_resp}, {1'b1, exp_resp});
    check({tag, "_b_id"}, {rsp.b_id, rsp.b_user}, {id, 1'b0});
    step();
    req.b_ready = 1'b0;
    check({tag, "_aw_idle"}, {rsp.aw_ready, rsp.b_valid}, 2'b10);
  endtask

  task automatic do_read(input logic [63:0] addr, input int len, input int size,
                         input int burst, input logic id, input string tag);
    int cnt;
    int idx;
    logic [63:0] a;
    logic [63:0] exp;
    logic [63:0] mask;
    logic [1:0] er;
    req.r_ready  = 1'b0;
    req.ar_id    = id;
    req.ar_addr  = addr;
    req.ar_len   = 8'(len);
    req.ar_size  = 3'(size);
    req.ar_burst = 2'(burst);
    req.ar_valid = 1'b1;
    cnt = 0;
    while (!rsp.ar_ready && cnt < 50) begin step(); cnt++; end
    check({tag, "_ar_ready"}, rsp.ar_ready, 1);
    step();
    req.ar_valid = 1'b0;
    check({tag, "_r_first"}, {rsp.r_valid, rsp.ar_ready}, 2'b10);
    for (int i = 0; i <= len; i++) begin
      a  = beat_addr(addr, size, len, burst, i);
      er = beat_resp(a, size, 1'b0);
      exp  = '0;
      mask = '0;
      if (er == 2'b00) begin
        for (int j = 0; j < 8; j++) begin
          idx = int'(a & ~64'd7) + j;
          if (mdl_v[idx]) begin
            exp[8*j +: 8]  = mdl[idx];
            mask[8*j +: 8] = 8'hFF;
          end
        end
      end else if (er == 2'b11) begin
        mask = '1;
      end
      req.r_ready = ($urandom_range(0, 2) != 0);
      cnt = 0;
      while (!(rsp.r_valid && req.r_ready) && cnt < 50) begin
        step();
        cnt++;
        req.r_ready = ($urandom_range(0, 2) != 0);
      end
      check({tag, "_r_hs"}, rsp.r_valid & req.r_ready, 1);
      rd[i] = rsp.r_data;
      if (mask != 64'd0) check({tag, "_r_data"}, rsp.r_data & mask, exp);
      check({tag, "_r_resp"}, rsp.r_resp, er);
      check({tag, "_r_last"}, rsp.r_last, (i == len));
      check({tag, "_r_id"}, {rsp.r_id, rsp.r_user}, {id, 1'b0});
      step();
    end
    req.r_ready = 1'b0;
    check({tag, "_r_done"}, {rsp.r_valid, rsp.ar_ready}, 2'b01);
  endtask

  initial begin
    int cnt;
    int burst;
    int size;
    int len;
    logic [63:0] addr;
    logic id;
    n_checks = 0;
    n_pass   = 0;
    req      = '0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {rsp.aw_ready, rsp.ar_ready, rsp.w_ready}, 3'b110);
    check("rst_valid", {rsp.b_valid, rsp.r_valid}, 2'b00);
    check("rst_payload", rsp.r_data | 64'(rsp.b_resp) | 64'(rsp.r_resp), 64'd0);
    rst_n = 1'b1;
    step();

    // Single-beat write/read.
    wd[0] = 64'h0000207098001032; ws[0] = 8'hFF;
    do_write(64'h28, 0, 3, 1, 6'd0, 0, 1'b0, "t1w");
    do_read(64'h28, 0, 3, 1, 1'b0, "t1r");
    check("t1_data", rd[0], 64'h0000207098001032);

    // Partial strobes.
    wd[0] = '1; ws[0] = 8'hFF;
    do_write(64'h30, 0, 3, 1, 6'd0, 0, 1'b1, "t2a");
    wd[0] = '0; ws[0] = 8'h0F;
    do_write(64'h30, 0, 3, 1, 6'd0, 0, 1'b1, "t2b");
    do_read(64'h30, 0, 3, 1, 1'b1, "t2r");
    check("t2_data", rd[0], 64'hFFFFFFFF00000000);

    // INCR 4 beats.
    for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
    do_write(64'h100, 3, 3, 1, 6'd0, 3, 1'b0, "t3w");
    do_read(64'h100, 3, 3, 1, 1'b0, "t3r");
    for (int i = 0; i < 4; i++) check("t3_data", rd[i], 64'(i + 1));

    // WRAP from 0x118: second beat lands on 0x100.
    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    do_write(64'h118, 3, 3, 2, 6'd0, 3, 1'b1, "t4w");
    do_read(64'h118, 3, 3, 2, 1'b1, "t4r");
    check("t4_wrap_b1", rd[1], wd[1]);
    do_read(64'h100, 0, 3, 1, 1'b0, "t4s");
    check("t4_at_100", rd[0], wd[1]);

    // DECERR read held with r_ready low.
    req.r_ready  = 1'b0;
    req.ar_addr  = 64'(Span);
    req.ar_len   = 8'd0;
    req.ar_size  = 3'd3;
    req.ar_burst = 2'd1;
    req.ar_id    = 1'b1;
    req.ar_valid = 1'b1;
    cnt = 0;
    while (!rsp.ar_ready && cnt < 50) begin step(); cnt++; end
    step();
    req.ar_valid = 1'b0;
    repeat (5) step();
    check("t5_hold_valid", {rsp.r_valid, rsp.r_last}, 2'b11);
    check("t5_hold_data", rsp.r_data, 64'd0);
    check("t5_hold_resp", rsp.r_resp, 2'b11);
    req.r_ready = 1'b1;
    step();
    req.r_ready = 1'b0;
    check("t5_done", rsp.r_valid, 0);

    // Beat count ends the burst without w_last; early w_last ends it sooner.
    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    do_write(64'h40, 1, 3, 1, 6'd0, -1, 1'b0, "t6a");
    do_write(64'h60, 3, 3, 1, 6'd0, 1, 1'b1, "t6b");
    do_read(64'h40, 1, 3, 1, 1'b0, "t6r");
    do_read(64'h60, 1, 3, 1, 1'b1, "t6s");

    // ATOP and oversize beats answer SLVERR without touching memory.
    wd[0] = 64'hDEAD_BEEF_DEAD_BEEF; ws[0] = 8'hFF;
    do_write(64'h28, 0, 3, 1, 6'h20, 0, 1'b1, "t7w");
    do_write(64'h28, 0, 4, 1, 6'd0, 0, 1'b0, "t8w");
    do_read(64'h28, 0, 3, 1, 1'b0, "t7r");
    check("t7_kept", rd[0], 64'h0000207098001032);
    do_read(64'h28, 1, 4, 1, 1'b0, "t8r");

    // Burst running off the end of the array.
    wd[0] = 64'h1111; wd[1] = 64'h2222; ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_write(64'(Span - 8), 1, 3, 1, 6'd0, 1, 1'b0, "t9w");
    do_read(64'(Span - 8), 1, 3, 1, 1'b0, "t9r");

    // Reset in the middle of a write burst.
    req.aw_addr  = 64'h200;
    req.aw_len   = 8'd3;
    req.aw_size  = 3'd3;
    req.aw_burst = 2'd1;
    req.aw_atop  = 6'd0;
    req.aw_id    = 1'b0;
    req.aw_valid = 1'b1;
    step();
    req.aw_valid = 1'b0;
    req.w_data   = 64'hCAFE_F00D_0123_4567;
    req.w_strb   = 8'hFF;
    req.w_last   = 1'b0;
    req.w_valid  = 1'b1;
    cnt = 0;
    while (!rsp.w_ready && cnt < 50) begin step(); cnt++; end
    step();
    req.w_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      mdl[16'h200 + j]   = req.w_data[8*j +: 8];
      mdl_v[16'h200 + j] = 1'b1;
    end
    rst_n = 1'b0;
    step();
    check("t10_rst", {rsp.b_valid, rsp.aw_ready, rsp.w_ready}, 3'b010);
    rst_n = 1'b1;
    step();
    wd[0] = 64'h0BAD_C0DE_5555_AAAA; ws[0] = 8'hFF;
    do_write(64'h208, 0, 3, 1, 6'd0, 0, 1'b1, "t10w");
    do_read(64'h200, 1, 3, 1, 1'b0, "t10r");
    check("t10_kept", rd[0], 64'hCAFE_F00D_0123_4567);

    // Random traffic.
    for (int k = 0; k < 40; k++) begin
      burst = $urandom_range(0, 2);
      size  = ($urandom_range(0, 9) == 0) ? 4 : $urandom_range(0, 3);
      len   = (burst == 2) ? (1 << $urandom_range(1, 3)) - 1 : $urandom_range(0, 7);
      addr  = ($urandom_range(0, 4) == 0) ? 64'(32'h1FC0 + $urandom_range(0, 63))
                                           : 64'($urandom_range(0, 'h7FF));
      if (burst == 2) addr = addr & ~((64'd1 << size) - 64'd1);
      id = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
        do_write(addr, len, size, burst, 6'd0, len, id, "rnd_w");
      end else begin
        do_read(addr, len, size, burst, id, "rnd_r");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
